// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage feeding a DEPTH-entry buffer of decoded
// control bundles, with valid/ready handshakes on both sides and flush.
// Optional build macro DECODE_ILLEGAL_TRAP_EN: report unsupported encodings
// on the illegal output. Without it, illegal is tied 0. In both builds such
// encodings decode as a NOP bundle.
module decode_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [14:0]     out_regs,
  output logic            reg_write,
  output logic [1:0]      result_src,
  output logic            mem_write,
  output logic            mem_read,
  output logic [2:0]      mem_width,
  output logic [3:0]      alu_control,
  output logic            alu_src,
  output logic            alu_src_a,
  output logic [2:0]      imm_control,
  output logic            branch,
  output logic            jump,
  output logic            jalr,
  output logic [2:0]      branch_type,
  output logic            illegal
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_sel_e;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [14:0]     regs;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            mem_read;
    logic [2:0]      mem_width;
    alu_op_e         alu_control;
    logic            alu_src;
    logic            alu_src_a;
    imm_sel_e        imm_control;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic [2:0]      branch_type;
    logic            illegal;
  } entry_t;

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;
  entry_t     dec;
  entry_t     head;
  entry_t     mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          enq, deq;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Combinational decode of the offered instruction into a buffer entry.
  always_comb begin
    dec             = '0;
    dec.pc          = in_pc;
    dec.regs        = {in_instr[11:7], in_instr[24:20], in_instr[19:15]};
    dec.alu_control = ALU_ADD;
    dec.imm_control = IMM_I;
    bad             = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write   = 1'b1;
        dec.alu_control = alu_sel(funct3, funct7[5], 1'b1);
        bad             = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OP_IALU: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = alu_sel(funct3, funct7[5], 1'b0);
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.mem_read   = 1'b1;
        dec.mem_width  = funct3;
        dec.alu_src    = 1'b1;
        bad            = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        dec.mem_write   = 1'b1;
        dec.mem_width   = funct3;
        dec.alu_src     = 1'b1;
        dec.imm_control = IMM_S;
        bad             = (funct3 > 3'b010);
      end
      OP_BRANCH: begin
        dec.branch      = 1'b1;
        dec.branch_type = funct3;
        dec.alu_control = ALU_SUB;
        dec.imm_control = IMM_B;
        bad             = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        dec.reg_write   = 1'b1;
        dec.result_src  = 2'b10;
        dec.jump        = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_src_a   = 1'b1;
        dec.imm_control = IMM_J;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = ALU_PASS_B;
        dec.imm_control = IMM_U;
      end
      OP_AUIPC: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_src_a   = 1'b1;
        dec.imm_control = IMM_U;
      end
      OP_FENCE, OP_SYSTEM: ;
      default: bad = 1'b1;
    endcase
    // Unsupported encodings collapse to a NOP bundle; PC and register indices are kept.
    if (bad) begin
      dec      = '0;
      dec.pc   = in_pc;
      dec.regs = {in_instr[11:7], in_instr[24:20], in_instr[19:15]};
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec.illegal = bad;
`endif
    if (dec.regs[14:10] == 5'd0) dec.reg_write = 1'b0;
  end

  assign out_valid = (count != '0);
  assign in_ready  = !reset && ((count < CW'(DEPTH)) || out_ready);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  // Occupancy and pointer update; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (enq) wptr <= ptr_inc(wptr);
      if (deq) rptr <= ptr_inc(rptr);
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

  // Entry storage; no reset needed since outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= dec;
  end

  // Present the head entry, or all zeros when the buffer is empty.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rptr];
  end

  assign out_pc      = head.pc;
  assign out_regs    = head.regs;
  assign reg_write   = head.reg_write;
  assign result_src  = head.result_src;
  assign mem_write   = head.mem_write;
  assign mem_read    = head.mem_read;
  assign mem_width   = head.mem_width;
  assign alu_control = head.alu_control;
  assign alu_src     = head.alu_src;
  assign alu_src_a   = head.alu_src_a;
  assign imm_control = head.imm_control;
  assign branch      = head.branch;
  assign jump        = head.jump;
  assign jalr        = head.jalr;
  assign branch_type = head.branch_type;
  assign illegal     = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=2): decode fields, back-pressure,
// flush, throughput and mid-operation reset.
module tb_decode_queue;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [14:0] out_regs;
  logic        reg_write, mem_write, mem_read, alu_src, alu_src_a;
  logic        branch, jump, jalr, illegal;
  logic [1:0]  result_src;
  logic [2:0]  mem_width, imm_control, branch_type;
  logic [3:0]  alu_control;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  decode_queue #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_regs(out_regs),
    .reg_write(reg_write), .result_src(result_src), .mem_write(mem_write),
    .mem_read(mem_read), .mem_width(mem_width), .alu_control(alu_control),
    .alu_src(alu_src), .alu_src_a(alu_src_a), .imm_control(imm_control),
    .branch(branch), .jump(jump), .jalr(jalr), .branch_type(branch_type),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for exactly one cycle with out_ready low.
  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_alu_control", alu_control, 0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    // addi x1,x0,5
    push(32'h00500093, 32'h100);
    check("addi_valid", out_valid, 1);
    check("addi_reg_write", reg_write, 1);
    check("addi_alu_src", alu_src, 1);
    check("addi_alu_control", alu_control, 0);
    check("addi_regs", out_regs, 15'h04A0);
    check("addi_pc", out_pc, 32'h100);
    pop();
    check("addi_popped", out_valid, 0);
    check("empty_pc_zero", out_pc, 0);

    // sub x2,x1,x2
    push(32'h40208133, 32'h104);
    check("sub_alu_control", alu_control, 1);
    check("sub_alu_src", alu_src, 0);
    check("sub_regs", out_regs, 15'h0841);
    pop();

    // add x0,x0,x0
    push(32'h00000033, 32'h108);
    check("add_x0_reg_write", reg_write, 0);
    pop();

    // auipc x0
    push(32'h12345017, 32'h10C);
    check("auipc_alu_src_a", alu_src_a, 1);
    check("auipc_imm", imm_control, 3'b100);
    check("auipc_result_src", result_src, 0);
    check("auipc_alu_control", alu_control, 0);
    pop();

    // lui x5
    push(32'h123452B7, 32'h110);
    check("lui_alu_control", alu_control, 10);
    check("lui_imm", imm_control, 3'b100);
    check("lui_result_src", result_src, 0);
    check("lui_reg_write", reg_write, 1);
    check("lui_alu_src_a", alu_src_a, 0);
    pop();

    // lw x3,8(x1)
    push(32'h0080A183, 32'h114);
    check("lw_mem_read", mem_read, 1);
    check("lw_result_src", result_src, 1);
    check("lw_mem_width", mem_width, 2);
    pop();

    // sw x2,4(x1)
    push(32'h0020A223, 32'h118);
    check("sw_mem_write", mem_write, 1);
    check("sw_reg_write", reg_write, 0);
    check("sw_imm", imm_control, 1);
    pop();

    // bne x1,x2,8
    push(32'h00209463, 32'h11C);
    check("bne_branch", branch, 1);
    check("bne_type", branch_type, 1);
    check("bne_alu_control", alu_control, 1);
    check("bne_imm", imm_control, 2);
    pop();

    // jalr x1,0(x5)
    push(32'h000280E7, 32'h120);
    check("jalr_jump", jump, 1);
    check("jalr_jalr", jalr, 1);
    check("jalr_result_src", result_src, 2);
    pop();

    // sra x3,x1,x2
    push(32'h4020D1B3, 32'h124);
    check("sra_alu_control", alu_control, 9);
    pop();

    // unsupported encoding
    push(32'hFFFFFFFF, 32'h128);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("ill_flag", illegal, 1);
`else
    check("ill_flag", illegal, 0);
`endif
    check("ill_reg_write", reg_write, 0);
    check("ill_mem_write", mem_write, 0);
    check("ill_alu_control", alu_control, 0);
    pop();

    // Back-pressure: fill to DEPTH, third offer stalls.
    push(32'h00500093, 32'h200);
    push(32'h00600093, 32'h204);
    check("bp_full_in_ready", in_ready, 0);
    check("bp_head_pc", out_pc, 32'h200);
    in_instr = 32'h00700093; in_pc = 32'h208; in_valid = 1'b1;
    tick();
    check("bp_stall_in_ready", in_ready, 0);
    check("bp_stall_head", out_pc, 32'h200);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_order_1", out_pc, 32'h204);
    tick();
    check("bp_order_2", out_pc, 32'h208);
    tick();
    check("bp_drained", out_valid, 0);
    out_ready = 1'b0;

    // Flush with two entries queued and an offered input.
    push(32'h00500093, 32'h300);
    push(32'h00500093, 32'h304);
    in_instr = 32'h00500093; in_pc = 32'h308; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_out_pc", out_pc, 0);
    tick();
    check("flush_input_dropped", out_valid, 0);

    // Sustained one-per-cycle flow.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_instr = 32'h00500093; in_pc = 32'h400 + 4 * i; in_valid = 1'b1;
      #1;
      check("tp_in_ready", in_ready, 1);
      tick();
      check("tp_valid", out_valid, 1);
      check("tp_pc", out_pc, 32'h400 + 4 * i);
    end
    in_valid = 1'b0;
    tick();
    check("tp_drained", out_valid, 0);
    out_ready = 1'b0;

    // Reset mid-operation empties the buffer.
    push(32'h00500093, 32'h500);
    check("mr_queued", out_valid, 1);
    reset = 1'b1;
    tick();
    check("mr_out_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
